// File: rtl/serial_tx_pkg.sv
// Shared definitions for the serial transmitter: FSM state encoding,
// line idle level and a width helper for the internal counters.
package serial_tx_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } tx_state_e;

    localparam logic IdleLevel = 1'b1;

    // Counter width for a modulus of 'value'; never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/serial_tx_if.sv
// Word handshake plus serial-line outputs of the serial transmitter.
interface serial_tx_if #(
    parameter int unsigned DATA_WIDTH = 16
) ();

    logic [DATA_WIDTH-1:0] in;
    logic                  valid;
    logic                  ready;
    logic                  tx;
    logic                  bit_strobe;
    logic                  busy;

    modport master (
        output in,
        output valid,
        input  ready,
        input  tx,
        input  bit_strobe,
        input  busy
    );

    modport slave (
        input  in,
        input  valid,
        output ready,
        output tx,
        output bit_strobe,
        output busy
    );

endinterface

// File: rtl/serial_tx_bit_timer.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1, flags the last cycle of the
// period and also what that flag will be after the next edge.
module serial_tx_bit_timer
    import serial_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick,
    output logic tick_next
);

    localparam int unsigned CntW = clog2_min1(CLKS_PER_BIT);
    localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick = (cnt_q == LastCnt);
        if (clr || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
        // Lets the owner register a strobe that lines up with the last cycle.
        tick_next = (cnt_d == LastCnt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_tx.sv
// Parallel-in, serial-out transmitter: start bit, DATA_WIDTH bits LSB first,
// stop bit, each held CLKS_PER_BIT clocks, with a per-data-bit strobe.
module serial_tx
    import serial_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cl,
    serial_tx_if.slave   bus
);

    localparam int unsigned BitW = clog2_min1(DATA_WIDTH);
    localparam logic [BitW-1:0] LastBit = BitW'(DATA_WIDTH - 1);

    tx_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [BitW-1:0]       bit_cnt_q, bit_cnt_d;
    logic                  tx_q, tx_d;
    logic                  strobe_q, strobe_d;
    logic                  tick, tick_next, timer_clr;

    // Holding the divider clear while idle makes acceptance restart the period.
    assign timer_clr = cl || (state_q == StIdle);

    serial_tx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk       (clk),
        .rst       (rst),
        .clr       (timer_clr),
        .tick      (tick),
        .tick_next (tick_next)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;

        if (cl) begin
            state_d   = StIdle;
            bit_cnt_d = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.valid) begin
                        state_d = StStart;
                        shreg_d = bus.in;
                    end
                end
                StStart: begin
                    if (tick) begin
                        state_d   = StData;
                        bit_cnt_d = '0;
                    end
                end
                StData: begin
                    if (tick) begin
                        shreg_d = shreg_q >> 1;
                        if (bit_cnt_q == LastBit) begin
                            state_d   = StStop;
                            bit_cnt_d = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BitW'(1);
                        end
                    end
                end
                StStop: begin
                    if (tick) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        // Outputs are registered, so decode them from the next state.
        case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shreg_d[0];
            default: tx_d = IdleLevel;
        endcase
        strobe_d = (state_d == StData) && tick_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= IdleLevel;
            strobe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            strobe_q  <= strobe_d;
        end
    end

    assign bus.ready      = (state_q == StIdle);
    assign bus.busy       = (state_q != StIdle);
    assign bus.tx         = tx_q;
    assign bus.bit_strobe = strobe_q;

endmodule
